// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types and constants for the scope capture path
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARM       = 2'd1,
    CAPTURE   = 2'd2,
    WAIT_SWAP = 2'd3
  } capture_state_t;

  typedef enum logic [1:0] {
    TRIG_AUTO   = 2'd0,
    TRIG_RISE   = 2'd1,
    TRIG_FALL   = 2'd2,
    TRIG_SINGLE = 2'd3
  } trig_mode_t;

  localparam int SAMPLE_DEPTH = 256;

endpackage

// File: rtl/trig_detect.sv
// rtl/trig_detect.sv - level-crossing trigger against the previous valid sample
module trig_detect
  import vga_pkg::*;
#(
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  input  logic [DATA_W-1:0] trig_level,
  input  trig_mode_t        mode,
  output logic              trig_hit
);

  logic [DATA_W-1:0] prev_q;
  logic              prev_valid_q;
  logic              rise;
  logic              fall;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else if (en && adc_valid) begin
      prev_q       <= adc_data;
      prev_valid_q <= 1'b1;
    end
  end

  assign rise = (prev_q < trig_level) && (adc_data >= trig_level);
  assign fall = (prev_q > trig_level) && (adc_data <= trig_level);

  // Auto and single modes share rising detection with normal rising.
  assign trig_hit = en && adc_valid && prev_valid_q &&
                    ((mode == TRIG_FALL) ? fall : rise);

endmodule

// File: rtl/capture_ctrl.sv
// rtl/capture_ctrl.sv - triggered 256-sample capture into a vblank-swapped double buffer
module capture_ctrl
  import vga_pkg::*;
#(
  parameter int DEPTH   = SAMPLE_DEPTH,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 12,
  parameter int AUTO_TO = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [1:0]        trig_mode,
  input  logic              run,
  input  logic              vblnk,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              bank_sel,
  output logic              frame_ready,
  output logic [1:0]        state
);

  localparam int TO_W = $clog2(AUTO_TO + 1);
  localparam logic [TO_W-1:0]   TO_MAX    = '1;
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(AUTO_TO - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  capture_state_t    state_q, state_d;
  trig_mode_t        mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              bank_q, bank_d;
  logic              frame_q, frame_d;
  logic              vblnk_q;
  logic              td_clear;
  logic              trig_hit;

  trig_detect #(
    .DATA_W(DATA_W)
  ) u_trig_detect (
    .clk       (clk),
    .rst       (rst),
    .clear     (td_clear),
    .en        (state_q == ARM),
    .adc_valid (adc_valid),
    .adc_data  (adc_data),
    .trig_level(trig_level),
    .mode      (mode_q),
    .trig_hit  (trig_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= TRIG_AUTO;
      addr_q    <= '0;
      to_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      bank_q    <= 1'b0;
      frame_q   <= 1'b0;
      vblnk_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      addr_q    <= addr_d;
      to_q      <= to_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      bank_q    <= bank_d;
      frame_q   <= frame_d;
      vblnk_q   <= vblnk;
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    addr_d    = addr_q;
    to_d      = to_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    bank_d    = bank_q;
    frame_d   = 1'b0;
    td_clear  = 1'b0;

    case (state_q)
      IDLE: begin
        mode_d   = trig_mode_t'(trig_mode);
        to_d     = '0;
        td_clear = 1'b1;
        if (run) state_d = ARM;
      end

      ARM: begin
        if (adc_valid) begin
          to_d = (to_q == TO_MAX) ? to_q : to_q + TO_W'(1);
          // A timeout landing on a real crossing still yields a single trigger.
          if (trig_hit || (mode_q == TRIG_AUTO && to_q == TO_LAST)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            wr_data_d = adc_data;
            addr_d    = ADDR_W'(1);
            state_d   = CAPTURE;
          end
        end
      end

      CAPTURE: begin
        if (adc_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = adc_data;
          addr_d    = addr_q + ADDR_W'(1);
          if (addr_q == ADDR_LAST) state_d = WAIT_SWAP;
        end
      end

      WAIT_SWAP: begin
        if (vblnk && !vblnk_q) begin
          bank_d  = ~bank_q;
          frame_d = 1'b1;
          if (mode_q == TRIG_SINGLE || !run) begin
            state_d = IDLE;
          end else begin
            state_d  = ARM;
            to_d     = '0;
            td_clear = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign bank_sel    = bank_q;
  assign frame_ready = frame_q;
  assign state       = state_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb/tb_capture_ctrl.sv - self-checking bench for capture_ctrl
module tb_capture_ctrl;

  localparam int DEPTH   = 256;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 12;
  localparam int AUTO_TO = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              adc_valid = 1'b0;
  logic [DATA_W-1:0] adc_data = '0;
  logic [DATA_W-1:0] trig_level = '0;
  logic [1:0]        trig_mode = '0;
  logic              run = 1'b0;
  logic              vblnk = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              bank_sel;
  logic              frame_ready;
  logic [1:0]        state;

  int n_chk = 0;
  int n_fail = 0;
  int wr_total = 0;
  int fr_total = 0;
  int base = 0;
  int fbase = 0;

  // Behavioural model: phase 0 idle, 1 armed, 2 capturing, 3 waiting for vblank.
  int m_phase = 0, m_mode = 0, m_prev = 0, m_prev_ok = 0, m_tcnt = 0;
  int m_n = 0, m_bank = 0, m_vq = 0;
  int e_wr = 0, e_addr = 0, e_data = 0, e_fr = 0;

  always #5 clk = ~clk;

  capture_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .AUTO_TO(AUTO_TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .adc_valid  (adc_valid),
    .adc_data   (adc_data),
    .trig_level (trig_level),
    .trig_mode  (trig_mode),
    .run        (run),
    .vblnk      (vblnk),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .bank_sel   (bank_sel),
    .frame_ready(frame_ready),
    .state      (state)
  );

  always @(posedge clk) begin
    int d, l, hit;
    e_wr = 0;
    e_fr = 0;
    if (rst) begin
      m_phase = 0; m_mode = 0; m_prev_ok = 0; m_tcnt = 0; m_n = 0;
      m_bank = 0; m_vq = 0; e_addr = 0; e_data = 0;
    end else begin
      d = int'(adc_data);
      l = int'(trig_level);
      case (m_phase)
        0: begin
          m_mode = int'(trig_mode);
          m_prev_ok = 0;
          m_tcnt = 0;
          if (run) m_phase = 1;
        end
        1: if (adc_valid) begin
          m_tcnt = m_tcnt + 1;
          if (m_mode == 2) hit = (m_prev_ok != 0 && m_prev > l && d <= l) ? 1 : 0;
          else             hit = (m_prev_ok != 0 && m_prev < l && d >= l) ? 1 : 0;
          if (m_mode == 0 && m_tcnt == AUTO_TO) hit = 1;
          m_prev = d;
          m_prev_ok = 1;
          if (hit != 0) begin
            e_wr = 1; e_addr = 0; e_data = d; m_n = 1; m_phase = 2;
          end
        end
        2: if (adc_valid) begin
          e_wr = 1; e_addr = m_n; e_data = d;
          m_n = m_n + 1;
          if (m_n == DEPTH) m_phase = 3;
        end
        default: if (vblnk && m_vq == 0) begin
          m_bank = 1 - m_bank;
          e_fr = 1;
          if (m_mode == 3 || !run) m_phase = 0;
          else begin m_phase = 1; m_prev_ok = 0; m_tcnt = 0; end
        end
      endcase
      m_vq = vblnk ? 1 : 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("state", int'(state), m_phase);
    chk("wr_en", int'(wr_en), e_wr);
    if (e_wr != 0) begin
      chk("wr_addr", int'(wr_addr), e_addr);
      chk("wr_data", int'(wr_data), e_data);
    end
    chk("bank_sel", int'(bank_sel), m_bank);
    chk("frame_ready", int'(frame_ready), e_fr);
    if (wr_en) wr_total++;
    if (frame_ready) fr_total++;
    #1;
  endtask

  task automatic send(input int d);
    adc_valid = 1'b1;
    adc_data = DATA_W'(d);
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    trig_level = 12'd2048;
    #1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_state", int'(state), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_bank", int'(bank_sel), 0);
    chk("rst_frame", int'(frame_ready), 0);

    // Rising trigger on a ramp, then a clean swap back into ARM.
    trig_mode = 2'd1;
    run = 1'b1;
    tick();
    chk("rise_armed", int'(state), 1);
    base = wr_total;
    fbase = fr_total;
    for (int i = 0; i < 5; i++) send(2000 + 10 * i);
    chk("rise_no_early", wr_total - base, 0);
    send(2050);
    chk("rise_first_en", int'(wr_en), 1);
    chk("rise_first_addr", int'(wr_addr), 0);
    chk("rise_first_data", int'(wr_data), 2050);
    for (int i = 6; i <= 260; i++) send((2000 + 10 * i) % 4096);
    chk("rise_count", wr_total - base, 256);
    chk("rise_last_addr", int'(wr_addr), 255);
    tick();
    chk("rise_wait", int'(state), 3);
    repeat (4) send(1);
    chk("rise_dropped", wr_total - base, 256);
    vblnk = 1'b1;
    tick();
    chk("rise_swap_bank", int'(bank_sel), 1);
    chk("rise_swap_pulse", int'(frame_ready), 1);
    vblnk = 1'b0;
    tick();
    chk("rise_pulse_once", fr_total - fbase, 1);
    chk("rise_rearm", int'(state), 1);

    // Falling trigger, run dropped mid-capture, completion while vblank is high.
    do_reset();
    trig_mode = 2'd2;
    tick();
    base = wr_total;
    fbase = fr_total;
    send(1000);
    chk("fall_first_ignored", wr_total - base, 0);
    send(3000);
    chk("fall_no_trig_up", wr_total - base, 0);
    send(1000);
    chk("fall_trig_en", int'(wr_en), 1);
    chk("fall_trig_addr", int'(wr_addr), 0);
    chk("fall_trig_data", int'(wr_data), 1000);
    for (int i = 1; i <= 254; i++) begin
      if (i == 128) run = 1'b0;
      send(i * 7);
    end
    vblnk = 1'b1;
    send(4000);
    chk("fall_count", wr_total - base, 256);
    repeat (5) tick();
    chk("gate_no_swap_bank", int'(bank_sel), 0);
    chk("gate_still_wait", int'(state), 3);
    vblnk = 1'b0;
    tick();
    tick();
    chk("gate_no_pulse", fr_total - fbase, 0);
    vblnk = 1'b1;
    tick();
    chk("gate_swap_bank", int'(bank_sel), 1);
    chk("gate_swap_pulse", int'(frame_ready), 1);
    chk("run_off_idle", int'(state), 0);
    vblnk = 1'b0;
    tick();

    // Auto mode forces a trigger on the AUTO_TO-th flat sample.
    rst = 1'b1;
    trig_mode = 2'd0;
    run = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    base = wr_total;
    repeat (15) send(100);
    chk("auto_not_yet", wr_total - base, 0);
    send(100);
    chk("auto_trig_en", int'(wr_en), 1);
    chk("auto_trig_addr", int'(wr_addr), 0);
    chk("auto_trig_data", int'(wr_data), 100);
    repeat (255) send(100);
    chk("auto_count", wr_total - base, 256);
    repeat (10) send(100);
    chk("auto_count_hold", wr_total - base, 256);
    tick();
    vblnk = 1'b1;
    tick();
    chk("auto_swap_bank", int'(bank_sel), 1);
    vblnk = 1'b0;
    tick();
    chk("auto_rearm", int'(state), 1);

    // Single mode returns to IDLE after one swap even with run held high.
    do_reset();
    trig_mode = 2'd3;
    tick();
    base = wr_total;
    for (int i = 0; i <= 260; i++) send((2000 + 10 * i) % 4096);
    chk("single_count", wr_total - base, 256);
    trig_mode = 2'd1;
    tick();
    vblnk = 1'b1;
    tick();
    chk("single_idle", int'(state), 0);
    chk("single_bank", int'(bank_sel), 1);
    vblnk = 1'b0;
    tick();
    chk("single_rearm", int'(state), 1);

    // Reset after the 100th write abandons the bank and restarts at address 0.
    base = wr_total;
    for (int i = 0; i < 300 && (wr_total - base) < 100; i++) send((2000 + 10 * i) % 4096);
    chk("mid_count", wr_total - base, 100);
    chk("mid_bank_before", int'(bank_sel), 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_state", int'(state), 0);
    chk("mid_rst_bank", int'(bank_sel), 0);
    chk("mid_rst_wr_en", int'(wr_en), 0);
    rst = 1'b0;
    tick();
    for (int i = 0; i <= 5; i++) send(2000 + 10 * i);
    chk("restart_en", int'(wr_en), 1);
    chk("restart_addr", int'(wr_addr), 0);
    chk("restart_data", int'(wr_data), 2050);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
